// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path and the avs_uart register file.
// Holds the receiver state encoding, divisor floor and register indices.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rxState_e;

   localparam int MIN_DIV           = 4;
   localparam int DATA_BITS_DEFAULT = 8;

   localparam logic [2:0] RX_DATA = 3'd0;
   localparam logic [2:0] TX_DATA = 3'd1;
   localparam logic [2:0] CONTROL = 3'd2;
   localparam logic [2:0] STATUS  = 3'd3;
   localparam logic [2:0] CLK_DIV = 3'd4;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous, idle-high serial line.
// Both flops reset to 1 so a reset never looks like a start bit.
module uart_sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling 8N1 receive engine feeding the avs_uart rx_data and status registers.
// Samples mid-bit using a divisor latched at start detection, LSB first.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEFAULT,
   parameter int DIV_W     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_W-1:0]     clk_div,
   input  logic                 rx,
   input  logic                 rd_ack,
   input  logic                 err_clr,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 overrun,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   rxState_e             state_q, state_d;
   logic [DIV_W-1:0]     cnt_q, cnt_d;
   logic [DIV_W-1:0]     divLatch_q, divLatch_d;
   logic [BC_W-1:0]      bitCnt_q, bitCnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 deliver_q, deliver_d;
   logic [DATA_BITS-1:0] rxData_q, rxData_d;
   logic                 rxValid_q, rxValid_d;
   logic                 overrun_q, overrun_d;
   logic                 frameErr_q, frameErr_d;

   logic                 rxSync;
   logic [DIV_W-1:0]     divFloor;
   logic [DIV_W-1:0]     halfLast;
   logic [DIV_W-1:0]     bitLast;
   logic                 frameErrSet;

   uart_sync_2ff uSync (
      .clk   (clk),
      .reset (reset),
      .d_i   (rx),
      .q_o   (rxSync)
   );

   assign divFloor = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div;
   assign halfLast = (divLatch_q >> 1) - DIV_W'(1);
   assign bitLast  = divLatch_q - DIV_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         divLatch_q <= '0;
         bitCnt_q   <= '0;
         shift_q    <= '0;
         deliver_q  <= 1'b0;
         rxData_q   <= '0;
         rxValid_q  <= 1'b0;
         overrun_q  <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         divLatch_q <= divLatch_d;
         bitCnt_q   <= bitCnt_d;
         shift_q    <= shift_d;
         deliver_q  <= deliver_d;
         rxData_q   <= rxData_d;
         rxValid_q  <= rxValid_d;
         overrun_q  <= overrun_d;
         frameErr_q <= frameErr_d;
      end
   end

   // Frame sequencing: START checks the half-bit point so later samples land mid-bit.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      divLatch_d  = divLatch_q;
      bitCnt_d    = bitCnt_q;
      shift_d     = shift_q;
      deliver_d   = 1'b0;
      frameErrSet = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rxSync) begin
               divLatch_d = divFloor;
               cnt_d      = '0;
               state_d    = START;
            end
         end
         START: begin
            if (cnt_q == halfLast) begin
               cnt_d = '0;
               if (!rxSync) begin
                  bitCnt_d = '0;
                  state_d  = DATA;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == bitLast) begin
               cnt_d   = '0;
               shift_d = {rxSync, shift_q[DATA_BITS-1:1]};
               if (bitCnt_q == BC_W'(DATA_BITS - 1)) begin
                  state_d = STOP;
               end else begin
                  bitCnt_d = bitCnt_q + BC_W'(1);
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == bitLast) begin
               cnt_d = '0;
               if (rxSync) begin
                  deliver_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  frameErrSet = 1'b1;
                  state_d     = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         WAIT_HIGH: begin
            if (rxSync) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Register-facing outputs; a new error event overrides a simultaneous clear.
   always_comb begin
      rxData_d   = rxData_q;
      rxValid_d  = rxValid_q;
      overrun_d  = overrun_q;
      frameErr_d = frameErr_q;

      if (err_clr) begin
         overrun_d  = 1'b0;
         frameErr_d = 1'b0;
      end

      if (deliver_q) begin
         if (!rxValid_q || rd_ack) begin
            rxData_d  = shift_q;
            rxValid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rd_ack) begin
         rxValid_d = 1'b0;
      end

      if (frameErrSet) begin
         frameErr_d = 1'b1;
      end
   end

   assign rx_data   = rxData_q;
   assign rx_valid  = rxValid_q;
   assign overrun   = overrun_q;
   assign frame_err = frameErr_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed 8N1 scenarios plus randomized frames.
// Expected register contents come from a frame-level model of the receiver's delivery rules.
module tb_uart_rx_core;

   logic        clk;
   logic        reset;
   logic [31:0] clkDiv;
   logic        rx;
   logic        rdAck;
   logic        errClr;
   logic [7:0]  rxData;
   logic        rxValid;
   logic        overrun;
   logic        frameErr;
   logic        busy;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   // Frame-level model of what the register file should see
   logic [7:0] mData;
   logic       mValid;
   logic       mOverrun;
   logic       mFrameErr;

   int cycleCount = 0;
   int riseCycle  = -1;
   logic prevValid = 1'b0;

   uart_rx_core #(
      .DATA_BITS (8),
      .DIV_W     (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clk_div   (clkDiv),
      .rx        (rx),
      .rd_ack    (rdAck),
      .err_clr   (errClr),
      .rx_data   (rxData),
      .rx_valid  (rxValid),
      .overrun   (overrun),
      .frame_err (frameErr),
      .busy      (busy)
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter used for latency measurement
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Records the cycle on which rx_valid rises, sampled on the falling edge
   always @(negedge clk) begin
      if (rxValid === 1'b1 && prevValid !== 1'b1) riseCycle = cycleCount;
      prevValid = rxValid;
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      mData = 8'h00; mValid = 1'b0; mOverrun = 1'b0; mFrameErr = 1'b0;
   endtask

   task automatic modelAck();
      mValid = 1'b0;
   endtask

   task automatic modelErrClr();
      mOverrun = 1'b0; mFrameErr = 1'b0;
   endtask

   // A good frame lands only if the holding register is free; otherwise it is lost as overrun
   task automatic modelFrame(input logic [7:0] b, input logic stopGood);
      if (!stopGood) mFrameErr = 1'b1;
      else if (!mValid) begin
         mData = b; mValid = 1'b1;
      end else mOverrun = 1'b1;
   endtask

   task automatic compareAll(input string tag);
      checkOutput({tag, "_rx_data"}, 32'(rxData), 32'(mData));
      checkOutput({tag, "_rx_valid"}, 32'(rxValid), 32'(mValid));
      checkOutput({tag, "_overrun"}, 32'(overrun), 32'(mOverrun));
      checkOutput({tag, "_frame_err"}, 32'(frameErr), 32'(mFrameErr));
   endtask

   task automatic pulseAck();
      rdAck = 1'b1; waitCycles(1); rdAck = 1'b0;
      modelAck();
   endtask

   task automatic pulseErrClr();
      errClr = 1'b1; waitCycles(1); errClr = 1'b0;
      modelErrClr();
   endtask

   // Drives one frame LSB first; stopLowBits>0 holds the stop bit low and leaves rx low
   task automatic applyStimulus(input logic [7:0] b, input int bitLen, input int stopLowBits,
                                input int divAfter, input bit ackInStart);
      rx = 1'b0;
      if (ackInStart) begin
         rdAck = 1'b1; waitCycles(1); rdAck = 1'b0;
         modelAck();
         waitCycles(bitLen - 1);
      end else begin
         waitCycles(bitLen);
      end
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == 4 && divAfter != 0) clkDiv = divAfter;
         waitCycles(bitLen);
      end
      if (stopLowBits == 0) begin
         rx = 1'b1; waitCycles(bitLen);
      end else begin
         rx = 1'b0; waitCycles(stopLowBits * bitLen);
      end
   endtask

   initial begin
      int lat;
      int startCycle;
      logic [7:0] b;
      int d;
      bit badStop;

      reset = 1'b1; rx = 1'b1; clkDiv = 32'd8; rdAck = 1'b0; errClr = 1'b0;
      modelReset();
      waitCycles(3);
      reset = 1'b0;
      waitCycles(2);
      compareAll("reset");
      checkOutput("reset_busy", 32'(busy), 32'd0);

      // Single frame at 8 clocks per bit with latency window
      riseCycle  = -1;
      startCycle = cycleCount;
      applyStimulus(8'hA5, 8, 0, 0, 1'b0);
      modelFrame(8'hA5, 1'b1);
      waitCycles(3);
      lat = riseCycle - startCycle;
      checkOutput("t1_latency_in_window", 32'(lat >= 77 && lat <= 83), 32'd1);
      compareAll("t1");
      pulseAck();

      // Back-to-back frames at 16 clocks per bit, acked during the second start bit
      clkDiv = 32'd16;
      applyStimulus(8'h3C, 16, 0, 0, 1'b0);
      modelFrame(8'h3C, 1'b1);
      checkOutput("t2_first_data", 32'(rxData), 32'h3C);
      checkOutput("t2_first_valid", 32'(rxValid), 32'd1);
      applyStimulus(8'hC3, 16, 0, 0, 1'b1);
      modelFrame(8'hC3, 1'b1);
      waitCycles(3);
      compareAll("t2");
      pulseAck();

      // Overrun when the first byte is never read, then cleared
      clkDiv = 32'd8;
      applyStimulus(8'h11, 8, 0, 0, 1'b0);
      modelFrame(8'h11, 1'b1);
      applyStimulus(8'h22, 8, 0, 0, 1'b0);
      modelFrame(8'h22, 1'b1);
      waitCycles(3);
      compareAll("t3_overrun");
      pulseErrClr();
      waitCycles(1);
      compareAll("t3_cleared");
      pulseAck();

      // Break: stop bit held low for 30 bit times
      applyStimulus(8'h55, 8, 30, 0, 1'b0);
      modelFrame(8'h55, 1'b0);
      checkOutput("t4_busy_in_break", 32'(busy), 32'd1);
      compareAll("t4_break");
      rx = 1'b1;
      waitCycles(4);
      checkOutput("t4_idle_after_break", 32'(busy), 32'd0);
      applyStimulus(8'h7E, 8, 0, 0, 1'b0);
      modelFrame(8'h7E, 1'b1);
      waitCycles(3);
      compareAll("t4_after");

      // Short glitch on idle line must be rejected
      rx = 1'b0; waitCycles(2);
      rx = 1'b1; waitCycles(10);
      checkOutput("t5_glitch_busy", 32'(busy), 32'd0);
      compareAll("t5_glitch");

      // Asynchronous reset in the middle of the data bits
      rx = 1'b0; waitCycles(8);
      rx = 1'b1; waitCycles(8);
      rx = 1'b0; waitCycles(8);
      checkOutput("t5_busy_mid_data", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      modelReset();
      compareAll("t5_async_reset");
      checkOutput("t5_reset_busy", 32'(busy), 32'd0);
      rx = 1'b1;
      waitCycles(2);
      reset = 1'b0;
      waitCycles(2);
      applyStimulus(8'h81, 8, 0, 0, 1'b0);
      modelFrame(8'h81, 1'b1);
      waitCycles(3);
      compareAll("t5_after_reset");
      pulseAck();

      // Divisor below the floor runs at 4 clocks per bit; mid-frame change ignored
      clkDiv = 32'd2;
      applyStimulus(8'hF0, 4, 0, 0, 1'b0);
      modelFrame(8'hF0, 1'b1);
      waitCycles(3);
      compareAll("t6_floor");
      pulseAck();
      b = 8'($urandom);
      applyStimulus(b, 4, 0, 32, 1'b0);
      modelFrame(b, 1'b1);
      waitCycles(3);
      compareAll("t6_div_change");

      // Randomized frames with random divisors, acks, clears and framing errors
      for (int n = 0; n < 10; n++) begin
         d = $urandom_range(4, 12);
         clkDiv = 32'(d);
         if ($urandom_range(0, 1) == 1) pulseAck();
         if ($urandom_range(0, 3) == 0) pulseErrClr();
         b = 8'($urandom);
         badStop = ($urandom_range(0, 3) == 0);
         applyStimulus(b, d, badStop ? 1 : 0, 0, 1'b0);
         modelFrame(b, !badStop);
         if (badStop) begin
            rx = 1'b1;
            waitCycles(4);
         end
         waitCycles(3);
         compareAll($sformatf("rand%0d", n));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
